// File: rtl/fft_pease_sched_pkg.sv
// Purpose : shared types and helpers for the FFT Pease scheduler (state enum, arbitration helpers).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: sched_state_e (IDLE/ISSUE/WAIT/RESP), REQ_CNT, rr_pick(), req_onehot().
package fft_pease_sched_pkg;

    // Number of requesters sharing the FFT engine.
    localparam int unsigned REQ_CNT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    // Pick a winner from two valid flags. On a tie the requester that was
    // not served last wins; a single valid requester always wins.
    // Passing last_served = 1 makes requester 0 the fixed tie winner.
    function automatic logic rr_pick(input logic [1:0] vld, input logic last_served);
        logic idx;
        if (vld == 2'b11) begin
            idx = ~last_served;
        end else begin
            idx = vld[1] & ~vld[0];
        end
        return idx;
    endfunction

    // One-hot select of a requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        logic [1:0] oh;
        oh      = 2'b00;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/fft_pease_sched_Arbiter2.sv
// Purpose : two-way requester arbiter for the FFT scheduler; round-robin by default,
//           fixed priority (requester 0 wins ties) when FFT_SCHED_FIXED_PRIO_EN is defined.
// Latency : combinational grant; last_served updates one cycle after served_en_i.
// Backpressure: none; the grant is only meaningful while the parent FSM is idle.
// Ports   : clk/reset (sync, active-high), req_val_i[1:0] request flags,
//           served_en_i/served_idx_i record the requester whose response completed,
//           gnt_vld_o (any request), gnt_idx_o (winning requester).
// Config  : FFT_SCHED_FIXED_PRIO_EN -- fixed priority, last_served register not used.
module fft_pease_sched_Arbiter2
    import fft_pease_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_val_i,
    input  logic       served_en_i,
    input  logic       served_idx_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    assign gnt_vld_o = |req_val_i;

`ifdef FFT_SCHED_FIXED_PRIO_EN

    // Pinning the history to "1 served last" makes requester 0 win every tie.
    assign gnt_idx_o = rr_pick(req_val_i, 1'b1);

    // History inputs have no meaning in fixed-priority mode.
    logic unused_hist;
    assign unused_hist = ^{clk, reset, served_en_i, served_idx_i};

`else

    logic last_served_q;
    logic last_served_d;

    assign gnt_idx_o = rr_pick(req_val_i, last_served_q);

    always_comb begin
        last_served_d = last_served_q;
        if (served_en_i) begin
            last_served_d = served_idx_i;
        end
    end

    // Resets to 1 so that requester 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_served_q <= 1'b1;
        end else begin
            last_served_q <= last_served_d;
        end
    end

`endif

endmodule

// File: rtl/fft_pease_scheduler.sv
// Purpose : shares one FFT engine between two requesters; one frame in flight, single frame buffer.
// Latency : grant at cycle 0, fft_recv_val at cycle 1; respk_val one cycle after fft_send_val is sampled.
// Backpressure: holds in ISSUE while fft_recv_rdy=0 and in RESP while respk_rdy=0; no new grant until IDLE.
// Ports   : clk, reset (sync, active-high);
//           reqk_msg/val/rdy   requester-k input frame (rdy is combinational, high only for the winner in IDLE);
//           respk_msg/val/rdy  requester-k result frame;
//           fft_recv_*         frame issued to the engine; fft_send_* result returned by the engine;
//           owner              requester holding the grant; busy high whenever not IDLE.
// Config  : FFT_SCHED_FIXED_PRIO_EN -- requester 0 always wins ties (see fft_pease_sched_Arbiter2).
module fft_pease_scheduler
    import fft_pease_sched_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic [BIT_WIDTH*N_SAMPLES-1:0] req0_msg,
    input  logic                           req0_val,
    output logic                           req0_rdy,
    input  logic [BIT_WIDTH*N_SAMPLES-1:0] req1_msg,
    input  logic                           req1_val,
    output logic                           req1_rdy,

    output logic [BIT_WIDTH*N_SAMPLES-1:0] resp0_msg,
    output logic                           resp0_val,
    input  logic                           resp0_rdy,
    output logic [BIT_WIDTH*N_SAMPLES-1:0] resp1_msg,
    output logic                           resp1_val,
    input  logic                           resp1_rdy,

    output logic [BIT_WIDTH*N_SAMPLES-1:0] fft_recv_msg,
    output logic                           fft_recv_val,
    input  logic                           fft_recv_rdy,

    input  logic [BIT_WIDTH*N_SAMPLES-1:0] fft_send_msg,
    input  logic                           fft_send_val,
    output logic                           fft_send_rdy,

    output logic                           owner,
    output logic                           busy
);

    localparam int FRAME_W = BIT_WIDTH * N_SAMPLES;

    sched_state_e        state_q, state_d;
    logic [FRAME_W-1:0]  buf_q, buf_d;
    logic                owner_q, owner_d;

    // Handshake outputs registered from the next state.
    logic                busy_q;
    logic                fft_recv_val_q;
    logic                fft_send_rdy_q;
    logic [1:0]          resp_val_q;

    logic                gnt_vld;
    logic                gnt_idx;
    logic                served_en;
    logic                resp_rdy_sel;

    fft_pease_sched_Arbiter2 u_arb (
        .clk          (clk),
        .reset        (reset),
        .req_val_i    ({req1_val, req0_val}),
        .served_en_i  (served_en),
        .served_idx_i (owner_q),
        .gnt_vld_o    (gnt_vld),
        .gnt_idx_o    (gnt_idx)
    );

    // Request acceptance must be visible in the same cycle the request is
    // presented, so rdy is decoded combinationally from the arbiter.
    assign req0_rdy = (state_q == IDLE) && gnt_vld && !gnt_idx;
    assign req1_rdy = (state_q == IDLE) && gnt_vld &&  gnt_idx;

    assign resp_rdy_sel = owner_q ? resp1_rdy : resp0_rdy;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        owner_d   = owner_q;
        served_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    buf_d   = gnt_idx ? req1_msg : req0_msg;
                    owner_d = gnt_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fft_recv_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Result overwrites the input frame: only one frame is ever held.
                if (fft_send_val) begin
                    buf_d   = fft_send_msg;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_rdy_sel) begin
                    served_en = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            buf_q          <= '0;
            owner_q        <= 1'b0;
            busy_q         <= 1'b0;
            fft_recv_val_q <= 1'b0;
            fft_send_rdy_q <= 1'b0;
            resp_val_q     <= 2'b00;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            owner_q        <= owner_d;
            busy_q         <= (state_d != IDLE);
            fft_recv_val_q <= (state_d == ISSUE);
            fft_send_rdy_q <= (state_d == WAIT);
            resp_val_q     <= (state_d == RESP) ? req_onehot(owner_d) : 2'b00;
        end
    end

    // Message outputs always show the buffer; they only matter while the matching val is high.
    assign fft_recv_msg = buf_q;
    assign resp0_msg    = buf_q;
    assign resp1_msg    = buf_q;

    assign fft_recv_val = fft_recv_val_q;
    assign fft_send_rdy = fft_send_rdy_q;
    assign resp0_val    = resp_val_q[0];
    assign resp1_val    = resp_val_q[1];
    assign owner        = owner_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fft_pease_scheduler.sv
module tb_fft_pease_scheduler;

    localparam int BW = 32;
    localparam int NS = 8;
    localparam int FW = BW * NS;
    typedef logic [FW-1:0] frame_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    frame_t req0_msg = '0, req1_msg = '0, fft_send_msg = '0;
    frame_t resp0_msg, resp1_msg, fft_recv_msg;
    logic   req0_val = 1'b0, req1_val = 1'b0;
    logic   req0_rdy, req1_rdy;
    logic   resp0_val, resp1_val;
    logic   resp0_rdy = 1'b0, resp1_rdy = 1'b0;
    logic   fft_recv_val;
    logic   fft_recv_rdy = 1'b0;
    logic   fft_send_val = 1'b0;
    logic   fft_send_rdy;
    logic   owner, busy;

    always #5 clk = ~clk;

    fft_pease_scheduler #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_msg     (req0_msg),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req1_msg     (req1_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .resp0_msg    (resp0_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp1_msg    (resp1_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .fft_recv_msg (fft_recv_msg),
        .fft_recv_val (fft_recv_val),
        .fft_recv_rdy (fft_recv_rdy),
        .fft_send_msg (fft_send_msg),
        .fft_send_val (fft_send_val),
        .fft_send_rdy (fft_send_rdy),
        .owner        (owner),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Frames waiting to be offered by each requester (head is presented).
    frame_t pend0[$];
    frame_t pend1[$];

    // Stimulus knobs written by the main sequence.
    bit       rnd_mode   = 1'b0;
    bit       recv_stall = 1'b0;
    bit       send_hold  = 1'b0;
    bit [1:0] resp_hold  = 2'b00;

    // Monitor -> driver event flags for the edge that follows.
    bit     hs_req0 = 1'b0, hs_req1 = 1'b0, hs_recv = 1'b0, hs_send = 1'b0, mon_rst = 1'b1;
    frame_t mon_recv_frame = '0;

    // Transaction-level reference model.
    bit     m_busy  = 1'b0;
    int     m_owner = 0;
    int     m_last  = 1;
    bit     eng_has = 1'b0;
    frame_t m_eng_frame = '0;
    frame_t iss_q[$];
    frame_t resp_q[$];
    int     served[$];
    int     exp_order[$];

    int grant_cyc = 0, send_cyc = 0, lat_issue = -1, lat_resp = -1;
    bit lat_i_pend = 1'b0, lat_r_pend = 1'b0;
    int recv_hold_cnt = 0, resp_hold_cnt = 0;

    // Engine state owned by the driver.
    bit     eng_full = 1'b0;
    frame_t eng_frame = '0;
    int     eng_wait = 0;

    function automatic frame_t rand_frame();
        frame_t r;
        for (int i = 0; i < NS; i++) r[i*BW +: BW] = $urandom();
        return r;
    endfunction

    // Stand-in FFT transform: every sample inverted and offset by its index.
    function automatic frame_t xf(frame_t f);
        frame_t r;
        for (int i = 0; i < NS; i++) r[i*BW +: BW] = ~f[i*BW +: BW] + BW'(i);
        return r;
    endfunction

    // Arbitration rule: one valid requester wins outright; a tie goes to the
    // one not served last (or always to 0 with fixed priority).
    function automatic int pick(bit v0, bit v1, int last);
        if (v0 && v1) begin
`ifdef FFT_SCHED_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic check1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic checkf(string name, frame_t act, frame_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver: applies requester, engine and response-side inputs just after each edge.
    always @(posedge clk) begin
        #1;
        if (mon_rst) begin
            eng_full = 1'b0;
        end else begin
            if (hs_req0 && pend0.size() > 0) void'(pend0.pop_front());
            if (hs_req1 && pend1.size() > 0) void'(pend1.pop_front());
            if (hs_recv) begin
                eng_full  = 1'b1;
                eng_frame = xf(mon_recv_frame);
                eng_wait  = rnd_mode ? int'($urandom_range(0, 3)) : 0;
            end
            if (hs_send) eng_full = 1'b0;
        end
        req0_val = (pend0.size() != 0);
        req0_msg = req0_val ? pend0[0] : rand_frame();
        req1_val = (pend1.size() != 0);
        req1_msg = req1_val ? pend1[0] : rand_frame();
        fft_recv_rdy = !recv_stall && (!rnd_mode || $urandom_range(0, 2) != 0);
        if (eng_full && !send_hold) begin
            if (eng_wait > 0) begin
                eng_wait--;
                fft_send_val = 1'b0;
            end else begin
                fft_send_val = 1'b1;
            end
        end else begin
            fft_send_val = 1'b0;
        end
        fft_send_msg = eng_full ? eng_frame : rand_frame();
        resp0_rdy = !resp_hold[0] && (!rnd_mode || $urandom_range(0, 2) != 0);
        resp1_rdy = !resp_hold[1] && (!rnd_mode || $urandom_range(0, 2) != 0);
    end

    // Monitor / scoreboard: compares every output each cycle against the model.
    always @(negedge clk) begin
        bit do_grant;
        int win;
        cyc++;
        hs_req0 = 1'b0; hs_req1 = 1'b0; hs_recv = 1'b0; hs_send = 1'b0;
        if (reset) begin
            mon_rst = 1'b1;
            m_busy = 1'b0; m_owner = 0; m_last = 1; eng_has = 1'b0;
            iss_q.delete(); resp_q.delete();
            lat_i_pend = 1'b0; lat_r_pend = 1'b0;
        end else begin
            mon_rst  = 1'b0;
            do_grant = !m_busy && (req0_val || req1_val);
            win      = pick(req0_val, req1_val, m_last);
            check1("req0_rdy", req0_rdy, do_grant && win == 0);
            check1("req1_rdy", req1_rdy, do_grant && win == 1);
            check1("busy", busy, m_busy);
            check1("owner", owner, m_owner == 1);
            check1("fft_recv_val", fft_recv_val, iss_q.size() != 0);
            if (fft_recv_val && iss_q.size() != 0) checkf("fft_recv_msg", fft_recv_msg, iss_q[0]);
            check1("fft_send_rdy", fft_send_rdy, eng_has);
            check1("resp0_val", resp0_val, resp_q.size() != 0 && m_owner == 0);
            check1("resp1_val", resp1_val, resp_q.size() != 0 && m_owner == 1);
            if (resp0_val && resp_q.size() != 0 && m_owner == 0) checkf("resp0_msg", resp0_msg, resp_q[0]);
            if (resp1_val && resp_q.size() != 0 && m_owner == 1) checkf("resp1_msg", resp1_msg, resp_q[0]);

            if (recv_stall && fft_recv_val) recv_hold_cnt++;
            if (resp_hold[1] && resp1_val) resp_hold_cnt++;
            if (lat_i_pend && fft_recv_val) begin lat_issue = cyc - grant_cyc; lat_i_pend = 1'b0; end
            if (lat_r_pend && (resp0_val || resp1_val)) begin lat_resp = cyc - send_cyc; lat_r_pend = 1'b0; end

            if (resp_q.size() != 0 && (m_owner == 0 ? resp0_rdy : resp1_rdy)) begin
                void'(resp_q.pop_front());
                served.push_back(m_owner);
                m_last = m_owner;
                m_busy = 1'b0;
            end
            if (eng_has && fft_send_val) begin
                resp_q.push_back(xf(m_eng_frame));
                eng_has = 1'b0; hs_send = 1'b1;
                send_cyc = cyc; lat_r_pend = 1'b1;
            end
            if (iss_q.size() != 0 && fft_recv_rdy) begin
                m_eng_frame    = iss_q.pop_front();
                mon_recv_frame = fft_recv_msg;
                eng_has = 1'b1; hs_recv = 1'b1;
            end
            if (do_grant) begin
                iss_q.push_back(win == 0 ? req0_msg : req1_msg);
                m_busy = 1'b1; m_owner = win;
                if (win == 0) hs_req0 = 1'b1; else hs_req1 = 1'b1;
                grant_cyc = cyc; lat_i_pend = 1'b1;
            end
        end
    end

    function automatic bit cond(int what);
        case (what)
            0:       return m_busy;
            1:       return eng_has;
            default: return resp_q.size() != 0;
        endcase
    endfunction

    task automatic wait_for(string name, int what, int budget);
        for (int i = 0; i < budget; i++) begin
            if (cond(what)) return;
            @(posedge clk); #2;
        end
        n_cmp++; n_err++;
        $display("FAIL timeout %s: condition not reached in %0d cycles", name, budget);
    endtask

    task automatic wait_idle(string name, int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (pend0.size() == 0 && pend1.size() == 0 && !m_busy) return;
        end
        n_cmp++; n_err++;
        $display("FAIL timeout %s: still busy after %0d cycles, required idle", name, budget);
    endtask

    initial begin
        frame_t f;
        int     n_before;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk); #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_owner", owner, 1'b0);
        check1("rst_recv_val", fft_recv_val, 1'b0);
        check1("rst_send_rdy", fft_send_rdy, 1'b0);
        check1("rst_resp_val", resp0_val | resp1_val, 1'b0);
        @(posedge clk); #2;

        // Simultaneous requests straight from reset.
        served.delete();
`ifdef FFT_SCHED_FIXED_PRIO_EN
        repeat (3) pend0.push_back(rand_frame());
        pend1.push_back(rand_frame());
        exp_order = '{0, 0, 0, 1};
`else
        repeat (2) pend0.push_back(rand_frame());
        repeat (2) pend1.push_back(rand_frame());
        exp_order = '{0, 1, 0, 1};
`endif
        wait_idle("tie_order", 200);
        check_int("order_len", served.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < served.size(); i++)
            check_int("order_entry", served[i], exp_order[i]);

        // Single unit-impulse frame on requester 0: minimum latency.
        f = '0;
        f[BW-1:0] = 32'h0001_0000;
        n_before = served.size();
        pend0.push_back(f);
        wait_idle("impulse", 100);
        check_int("lat_issue", lat_issue, 1);
        check_int("lat_resp", lat_resp, 1);
        check_int("impulse_served", served.size(), n_before + 1);
        if (served.size() > n_before) check_int("impulse_owner", served[n_before], 0);

        // Response backpressure on requester 1 while requester 0 waits.
        resp_hold = 2'b10;
        resp_hold_cnt = 0;
        pend1.push_back(rand_frame());
        wait_for("hold_grant", 0, 50);
        pend0.push_back(rand_frame());
        wait_for("hold_resp", 2, 50);
        repeat (10) begin @(posedge clk); #2; end
        resp_hold = 2'b00;
        check_int("resp_hold_cycles", resp_hold_cnt, 10);
        wait_idle("resp_hold", 100);

        // Engine refuses the issued frame for 5 cycles; a second request must wait.
        recv_stall = 1'b1;
        recv_hold_cnt = 0;
        pend0.push_back(rand_frame());
        wait_for("stall_grant", 0, 50);
        pend1.push_back(rand_frame());
        repeat (5) begin @(posedge clk); #2; end
        recv_stall = 1'b0;
        check_int("recv_hold_cycles", recv_hold_cnt, 5);
        wait_idle("recv_stall", 100);

        // Requester 1 withdraws while requester 0 is being served.
        n_before = served.size();
        pend0.push_back(rand_frame());
        wait_for("drop_grant", 0, 50);
        pend1.push_back(rand_frame());
        @(posedge clk); #2;
        pend1.delete();
        wait_idle("drop", 100);
        repeat (3) begin @(posedge clk); #2; end
        check1("drop_busy", busy, 1'b0);
        check_int("drop_served", served.size(), n_before + 1);

        // Reset while the engine holds the frame.
        send_hold = 1'b1;
        pend0.push_back(rand_frame());
        wait_for("rst_wait", 1, 50);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        send_hold = 1'b0;
        @(negedge clk); #1;
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_recv_val", fft_recv_val, 1'b0);
        check1("midrst_send_rdy", fft_send_rdy, 1'b0);
        check1("midrst_resp_val", resp0_val | resp1_val, 1'b0);
        n_before = served.size();
        pend1.push_back(rand_frame());
        wait_idle("post_rst", 100);
        check_int("post_rst_served", served.size(), n_before + 1);
        if (served.size() > n_before) check_int("post_rst_owner", served[n_before], 1);

        // Randomized traffic with random engine and response stalls.
        rnd_mode = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 5) == 0 && pend0.size() < 3) pend0.push_back(rand_frame());
            if ($urandom_range(0, 5) == 0 && pend1.size() < 3) pend1.push_back(rand_frame());
            if (m_busy && pend1.size() > 0 && $urandom_range(0, 15) == 0) void'(pend1.pop_front());
        end
        wait_idle("random_drain", 3000);
        rnd_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
